// File: rtl/cam_burst_writer_if.sv
// AXI3 write-channel bundle between the camera burst writer (master) and the
// HP port / memory slave.
interface cam_burst_writer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cam_burst_writer.sv
// Writes the camera pixel stream into a circular DRAM frame buffer as fixed
// 16-beat AXI3 bursts, one burst outstanding, wrapping to base every frame.
module cam_burst_writer #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [31:0]       cfg_frame_bytes,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [63:0]       sdata,
    input  logic              sdata_valid,
    input  logic              sdata_burst_valid,
    output logic              sdata_ready,
    cam_burst_writer_if.master axi,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              err
);
    localparam int                BEAT_W      = $clog2(BURST_LEN);
    localparam int                BURST_BYTES = BURST_LEN * 8;
    localparam int                ALIGN_W     = $clog2(BURST_BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_frame_bytes;
    logic [31:0]       r_remaining;
    logic [BEAT_W-1:0] r_beat;
    logic [15:0]       r_frame_cnt;
    logic              r_err;
    logic              r_stop_pending;
    logic              r_frame_done;

    logic w_cfg_ok;
    logic w_wfire;
    logic w_bfire;
    logic w_last_burst;

    assign w_cfg_ok = (cfg_frame_bytes != '0)
                   && (cfg_frame_bytes[ALIGN_W-1:0] == '0)
                   && (cfg_base[ALIGN_W-1:0] == '0);

    assign w_wfire      = (r_state == S_DATA) && sdata_valid && axi.wready;
    assign w_bfire      = (r_state == S_RESP) && axi.bvalid;
    assign w_last_burst = (r_remaining == 32'(BURST_BYTES));

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cfg_start && w_cfg_ok) w_next = S_WAIT;
            S_WAIT: begin
                if (cfg_stop)               w_next = S_IDLE;
                else if (sdata_burst_valid) w_next = S_ADDR;
            end
            S_ADDR: if (axi.awready) w_next = S_DATA;
            S_DATA: if (w_wfire && (r_beat == LAST_BEAT)) w_next = S_RESP;
            // A stop arriving together with the response still ends capture here.
            S_RESP: if (axi.bvalid) w_next = (r_stop_pending || cfg_stop) ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_base         <= '0;
            r_addr         <= '0;
            r_frame_bytes  <= '0;
            r_remaining    <= '0;
            r_beat         <= '0;
            r_frame_cnt    <= '0;
            r_err          <= 1'b0;
            r_stop_pending <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (cfg_stop && (r_state inside {S_ADDR, S_DATA, S_RESP}))
                r_stop_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (cfg_start && w_cfg_ok) begin
                        r_base         <= cfg_base;
                        r_frame_bytes  <= cfg_frame_bytes;
                        r_addr         <= cfg_base;
                        r_remaining    <= cfg_frame_bytes;
                        r_err          <= 1'b0;
                        r_frame_cnt    <= '0;
                        r_stop_pending <= 1'b0;
                    end else if (cfg_start) begin
                        r_err <= 1'b1;
                    end
                end
                S_ADDR: if (axi.awready) r_beat <= '0;
                S_DATA: if (w_wfire) r_beat <= r_beat + BEAT_W'(1);
                S_RESP: begin
                    if (w_bfire) begin
                        if (axi.bresp != 2'b00) r_err <= 1'b1;
                        if (w_last_burst) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                            r_addr       <= r_base;
                            r_remaining  <= r_frame_bytes;
                        end else begin
                            r_addr      <= r_addr + ADDR_W'(BURST_BYTES);
                            r_remaining <= r_remaining - 32'(BURST_BYTES);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is only advanced in RESP, so it is stable for the whole ADDR phase.
    assign axi.awaddr   = r_addr;
    assign axi.awlen    = 4'(BURST_LEN - 1);
    assign axi.awvalid  = (r_state == S_ADDR);
    assign axi.wdata    = (r_state == S_DATA) ? sdata : '0;
    assign axi.wstrb    = 8'hFF;
    assign axi.wlast    = (r_state == S_DATA) && (r_beat == LAST_BEAT);
    assign axi.wvalid   = (r_state == S_DATA) && sdata_valid;
    assign axi.bready   = (r_state == S_RESP);
    assign sdata_ready  = (r_state == S_DATA) && axi.wready;

    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err        = r_err;
endmodule

// File: tb/tb_cam_burst_writer.sv
// Randomized bench for cam_burst_writer: stalling AXI slave, random stream
// gaps, and a frame-level model of addresses, data order and frame counting.
module tb_cam_burst_writer;
    logic        fclk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_base;
    logic [31:0] cfg_frame_bytes;
    logic        cfg_start;
    logic        cfg_stop;
    logic [63:0] sdata;
    logic        sdata_valid;
    logic        sdata_burst_valid;
    logic        sdata_ready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err;

    cam_burst_writer_if #(.ADDR_W(32)) axi ();

    cam_burst_writer #(.BURST_LEN(16), .ADDR_W(32)) dut (
        .fclk              (fclk),
        .rst_n             (rst_n),
        .cfg_base          (cfg_base),
        .cfg_frame_bytes   (cfg_frame_bytes),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .sdata             (sdata),
        .sdata_valid       (sdata_valid),
        .sdata_burst_valid (sdata_burst_valid),
        .sdata_ready       (sdata_ready),
        .axi               (axi),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_cnt         (frame_cnt),
        .err               (err)
    );

    always #5 fclk = ~fclk;

    int n_pass   = 0;
    int n_checks = 0;

    // Stream source and slave-side view of the same beats.
    logic [63:0] src_q[$];
    bit          src_adv;
    // Slave behaviour knobs.
    int aw_max, w_max, b_max, sv_pct;
    int aw_stall, w_stall, b_stall;
    bit b_pending, burst_open;
    int beat_in_burst, last_fire_beat, bad_burst_idx, stop_beat;
    // Frame-level model.
    logic [31:0] m_base;
    int nb, m_aw_idx, m_bursts, m_frames;
    bit fd_due;
    int fd_seen, ready_viol, awv_cycles;
    bit pend_start, pend_stop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: drive at the falling edge, observe 1ns later (before the rise).
    task automatic step();
        logic [31:0] e_addr;
        bit          fd_now;
        @(negedge fclk);
        cfg_start  = pend_start;
        cfg_stop   = pend_stop;
        pend_start = 1'b0;
        pend_stop  = 1'b0;
        if (src_adv) begin
            sdata = {$urandom, $urandom};
            src_q.push_back(sdata);
            src_adv = 1'b0;
        end
        sdata_valid = ($urandom_range(0, 99) < sv_pct);
        axi.awready = (aw_stall == 0);
        axi.wready  = (w_stall == 0);
        axi.bvalid  = b_pending && (b_stall == 0);
        axi.bresp   = (m_bursts == bad_burst_idx) ? 2'b10 : 2'b00;
        #1;
        fd_now = fd_due;
        fd_due = 1'b0;
        last_fire_beat = -1;
        if (sdata_valid && sdata_ready) src_adv = 1'b1;
        if (sdata_ready && !axi.wready) ready_viol++;
        if (axi.awvalid) awv_cycles++;
        if (frame_done || fd_now) check("frame_done", frame_done, fd_now);
        if (frame_done) fd_seen++;

        if (axi.awvalid && axi.awready) begin
            e_addr = m_base + 32'((m_aw_idx % nb) * 128);
            check("aw_one_outstanding", burst_open, 1'b0);
            check("awaddr", axi.awaddr, e_addr);
            check("awlen", axi.awlen, 4'hF);
            m_aw_idx++;
            burst_open    = 1'b1;
            beat_in_burst = 0;
            aw_stall      = $urandom_range(0, aw_max);
        end else if (aw_stall > 0) aw_stall--;

        if (axi.wvalid && axi.wready) begin
            check("w_inside_burst", burst_open, 1'b1);
            if (src_q.size() == 0) check("wdata_underflow", 1'b1, 1'b0);
            else check("wdata", axi.wdata, src_q.pop_front());
            check("wlast", axi.wlast, beat_in_burst == 15);
            check("wstrb", axi.wstrb, 8'hFF);
            last_fire_beat = beat_in_burst;
            beat_in_burst++;
            if (beat_in_burst == 16) b_pending = 1'b1;
            if (last_fire_beat == stop_beat) begin
                pend_stop = 1'b1;
                stop_beat = -1;
            end
            w_stall = $urandom_range(0, w_max);
        end else if (w_stall > 0) w_stall--;

        if (axi.bvalid && axi.bready) begin
            b_pending  = 1'b0;
            burst_open = 1'b0;
            m_bursts++;
            if (m_bursts % nb == 0) begin
                m_frames++;
                fd_due = 1'b1;
            end
            b_stall = $urandom_range(0, b_max);
        end else if (b_stall > 0) b_stall--;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] f, input bit ok);
        cfg_base        = b;
        cfg_frame_bytes = f;
        pend_start      = 1'b1;
        if (ok) begin
            m_base   = b;
            nb       = int'(f / 128);
            m_aw_idx = 0;
            m_bursts = 0;
            m_frames = 0;
        end
        step();
        step();
        check("busy_after_start", busy, ok);
        check("err_after_start", err, !ok);
        if (ok) check("frame_cnt_after_start", frame_cnt, 16'd0);
    endtask

    task automatic run_bursts(input int n, input int budget);
        int target = m_bursts + n;
        int c = 0;
        while (m_bursts < target && c < budget) begin
            step();
            c++;
        end
        check("run_bursts_done", 64'(m_bursts), 64'(target));
    endtask

    task automatic stop_idle(input int budget);
        int c = 0;
        pend_stop = 1'b1;
        step();
        while (busy && c < budget) begin
            step();
            c++;
        end
        check("stopped_idle", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_awvalid"}, axi.awvalid, 1'b0);
        check({tag, "_awaddr"}, axi.awaddr, 32'h0);
        check({tag, "_awlen"}, axi.awlen, 4'hF);
        check({tag, "_wstrb"}, axi.wstrb, 8'hFF);
        check({tag, "_wvalid"}, axi.wvalid, 1'b0);
        check({tag, "_wlast"}, axi.wlast, 1'b0);
        check({tag, "_bready"}, axi.bready, 1'b0);
        check({tag, "_sdata_ready"}, sdata_ready, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, 16'h0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int fd0, c;
        rst_n = 1'b0;
        cfg_base = '0; cfg_frame_bytes = '0; cfg_start = 1'b0; cfg_stop = 1'b0;
        sdata_burst_valid = 1'b1;
        sdata = {$urandom, $urandom};
        src_q.push_back(sdata);
        src_adv = 1'b0;
        aw_max = 0; w_max = 0; b_max = 0; sv_pct = 100;
        aw_stall = 0; w_stall = 0; b_stall = 0;
        b_pending = 1'b0; burst_open = 1'b0; beat_in_burst = 0;
        bad_burst_idx = -1; stop_beat = -1; pend_start = 1'b0; pend_stop = 1'b0;
        m_base = '0; nb = 1; m_aw_idx = 0; m_bursts = 0; m_frames = 0;
        fd_due = 1'b0; fd_seen = 0; ready_viol = 0; awv_cycles = 0;
        sdata_valid = 1'b1;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b00;

        repeat (3) @(negedge fclk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Basic frame: two bursts, one frame, then wrap to base.
        do_start(32'h1000_0000, 32'd256, 1'b1);
        fd0 = fd_seen;
        run_bursts(2, 200);
        c = 0;
        while (m_aw_idx < 3 && c < 50) begin step(); c++; end
        check("basic_third_aw", 64'(m_aw_idx), 64'd3);
        check("basic_frame_cnt", frame_cnt, 16'(m_frames));
        check("basic_frame_done_pulses", 64'(fd_seen - fd0), 64'd1);
        stop_idle(200);

        // Backpressure: 4 frames of 3 bursts with random stalls everywhere.
        aw_max = 5; w_max = 5; b_max = 3; sv_pct = 80;
        do_start(32'h2000_0000, 32'd384, 1'b1);
        fd0 = fd_seen;
        ready_viol = 0;
        run_bursts(12, 5000);
        repeat (2) step();
        check("bp_frame_cnt", frame_cnt, 16'(m_frames));
        check("bp_frames_model", 64'(m_frames), 64'd4);
        check("bp_frame_done_pulses", 64'(fd_seen - fd0), 64'd4);
        check("bp_ready_gated", 64'(ready_viol), 64'd0);
        stop_idle(500);

        // Error response on the second burst of a 4-burst frame.
        aw_max = 2; w_max = 2; b_max = 2; sv_pct = 90;
        do_start(32'h0800_0000, 32'd512, 1'b1);
        bad_burst_idx = 1;
        run_bursts(2, 1000);
        repeat (2) step();
        check("resp_err_set", err, 1'b1);
        run_bursts(2, 1000);
        repeat (2) step();
        check("resp_frame_cnt1", frame_cnt, 16'd1);
        bad_burst_idx = -1;
        run_bursts(4, 2000);
        repeat (2) step();
        check("resp_err_sticky", err, 1'b1);
        check("resp_frame_cnt2", frame_cnt, 16'(m_frames));
        stop_idle(500);

        // Stop on beat 7: the burst completes, then nothing more is issued.
        aw_max = 1; w_max = 1; b_max = 1; sv_pct = 100;
        do_start(32'h3000_0000, 32'd256, 1'b1);
        stop_beat = 7;
        run_bursts(1, 500);
        step();
        check("stop_idle_after_burst", busy, 1'b0);
        awv_cycles = 0;
        repeat (40) step();
        check("stop_no_more_aw", 64'(awv_cycles), 64'd0);
        check("stop_still_idle", busy, 1'b0);

        // Bad configurations, then a good start clears err.
        do_start(32'h1000_0000, 32'd200, 1'b0);
        do_start(32'h0000_0040, 32'd256, 1'b0);
        do_start(32'h1000_0000, 32'd0, 1'b0);
        aw_max = 0; w_max = 0; b_max = 0;
        do_start(32'h5000_0000, 32'd256, 1'b1);

        // Asynchronous reset while beat 9 is being offered.
        c = 0;
        while (last_fire_beat != 9 && c < 200) begin step(); c++; end
        check("rst_reached_beat9", 64'(last_fire_beat), 64'd9);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        src_q.delete();
        src_adv = 1'b1;
        burst_open = 1'b0; b_pending = 1'b0; beat_in_burst = 0; fd_due = 1'b0;
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        do_start(32'h5000_0000, 32'd256, 1'b1);
        run_bursts(2, 300);
        repeat (2) step();
        check("post_reset_frame_cnt", frame_cnt, 16'd1);
        stop_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cam_burst_writer.md
# cam_burst_writer

Consumes the 64-bit pixel stream that the camera block produces in the `fclk` domain (`sdata`/`sdata_valid`/`sdata_burst_valid`/`sdata_ready`) and writes it into a DRAM frame buffer as fixed 16-beat AXI3 write bursts. It sits between the camera and the HP port and generates sequential addresses across one frame. At the end of each frame it wraps to the base address, so capture is continuous. Frame completion is reported with a pulse and a counter.

## Interface
- `BURST_LEN`, 16: beats per burst; fixed, 128 bytes per burst.
- `ADDR_W`, 32: address width.
- `fclk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_base`  in  32  frame buffer base; must be 128-byte aligned.
- `cfg_frame_bytes`  in  32  bytes per frame; must be a nonzero multiple of 128.
- `cfg_start`  in  1  one-cycle pulse that starts capture.
- `cfg_stop`  in  1  one-cycle pulse that stops capture after the current burst.
- `sdata`  in  64  stream data.
- `sdata_valid`  in  1  stream valid.
- `sdata_burst_valid`  in  1  next 16 beats are guaranteed valid.
- `sdata_ready`  out  1  stream accept.
- `awaddr`  out  32  write address.
- `awlen`  out  4  burst length; constant 4'hF.
- `awvalid`  out  1  address valid.
- `awready`  in  1  address ready.
- `wdata`  out  64  write data.
- `wstrb`  out  8  byte strobes; constant 8'hFF.
- `wlast`  out  1  last beat of burst.
- `wvalid`  out  1  data valid.
- `wready`  in  1  data ready.
- `bresp`  in  2  write response.
- `bvalid`  in  1  response valid.
- `bready`  out  1  response ready.
- `busy`  out  1  high in any state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `frame_cnt`  out  16  completed frames; wraps modulo 2^16.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, WAIT, ADDR, DATA, RESP.
- **IDLE**
  - On `cfg_start` with valid config: latch base and frame_bytes; `addr`=base; `remaining`=frame_bytes; clear `err`, `frame_cnt` and `stop_pending`; go to WAIT.
  - On `cfg_start` with bad config (zero, not a multiple of 128, or base not 128-aligned): set `err`, stay in IDLE.
  - `cfg_stop` is ignored in IDLE.
- **WAIT**
  - `cfg_stop` → IDLE.
  - Otherwise, `sdata_burst_valid` → ADDR, with `awaddr`=addr and `awvalid`=1 registered.
  - If both occur in the same cycle, stop wins.
- **ADDR**
  - Hold `awvalid` and `awaddr` until `awready`, then go to DATA with `beat`=0.
- **DATA**
  - `wvalid` = `sdata_valid`, `sdata_ready` = `wready`, `wdata` = `sdata`; all combinational and only in DATA.
  - `wlast` = (`beat`==15).
  - Each `wvalid`&&`wready` handshake increments `beat`; the handshake on beat 15 → RESP.
  - A drop of `sdata_valid` mid-burst stalls the burst without error; the burst is never aborted.
- **RESP**
  - `bready`=1 (registered).
  - On `bvalid`:
    - If `bresp`≠0, set `err`.
    - Then `addr`+=128 and `remaining`-=128.
    - If `remaining` was 128: pulse `frame_done`, increment `frame_cnt`, reload `addr`=base and `remaining`=frame_bytes.
    - Next state is IDLE if `stop_pending`, else WAIT.
- `cfg_stop` in ADDR/DATA/RESP sets `stop_pending`; the burst in flight always completes.
- `cfg_start` outside IDLE is ignored.
- Only one burst is outstanding at any time.

## Timing
- Reset values: all outputs 0 except `awlen`=4'hF and `wstrb`=8'hFF. State=IDLE; `addr`, `remaining`, `beat`, `frame_cnt` = 0.
- `cfg_start` at cycle N: `busy`=1 at N+1.
- `sdata_burst_valid` in WAIT at cycle N: `awvalid`=1 at N+1.
- `awready` handshake at N: DATA from N+1, so the first beat can transfer at N+1.
- Beat-15 handshake at N: `bready`=1 at N+1.
- `bvalid` at N:
  - `bready`=0, next state, and the new `addr` all take effect at N+1.
  - `frame_done` is high for exactly cycle N+1.
- Best case is 16 data cycles plus 3 overhead cycles per burst.
- `addr` arithmetic is 32-bit and wraps modulo 2^32 without a flag.
- `rst_n` asserted mid-burst: immediate return to reset values. The partial AXI burst is abandoned; the system resets the interconnect alongside this block.

## Test plan
- Basic frame: base=0x1000_0000, frame_bytes=256, start, stream of 32 beats 0..31 with `awready`/`wready`/`bvalid` always 1.
  - → `awaddr` 0x1000_0000 then 0x1000_0080; `wlast` on beats 15 and 31; one `frame_done`; `frame_cnt`=1; third `awaddr`=0x1000_0000.
- Backpressure: random `awready`/`wready` stalls of 0-5 cycles, 4 frames of 384 bytes.
  - → data at the slave is in order with no loss or duplication; `frame_cnt`=4; `sdata_ready`==0 whenever `wready`==0.
- Stop mid-burst: `cfg_stop` on beat 7.
  - → burst finishes to beat 15 and RESP; IDLE; `busy`=0; no further `awvalid` even with `sdata_burst_valid`=1.
- Config errors: start with frame_bytes=200, and separately base=0x40.
  - → stays IDLE, `err`=1; a subsequent valid start clears `err`.
- Response error: `bresp`=2'b10 on burst 2 of 4.
  - → `err`=1 and stays 1; capture continues; `frame_cnt` still increments.
- Async reset: assert `rst_n` during DATA beat 9.
  - → all outputs at reset values within the same cycle; a fresh start restarts at base.
